sel_arb2: RTL and testbench

Two-channel round-robin arbiter sitting directly upstream of the dual-select output register (the `selA`/`selB` → `Q` capture stage). It accepts data from two independent valid/ready producers, buffers one word per channel, and drives `selA`/`QA` and `selB`/`QB` so that the two selects are never asserted together. The downstream stage's mutual-exclusion requirement therefore holds by construction rather than as an environment constraint.

---
 rtl/sel_arb_pkg.sv | 21 ++
 rtl/sel_arb2_if.sv | 25 ++
 rtl/sel_arb_slot.sv | 41 ++++
 rtl/sel_arb2.sv | 90 +++++++++
 tb/tb_sel_arb2.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sel_arb_pkg.sv
// Shared types for the two-channel select arbiter: grant encoding and round-robin channel id.
package sel_arb_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_t;
  typedef enum logic {CH_A, CH_B} ch_t;

  // A tie goes to the channel that was not granted last.
  function automatic gnt_t pick_grant(input logic a_full, input logic b_full, input ch_t rr_last);
    gnt_t g;
    g = GNT_NONE;
    if (a_full && b_full) begin
      g = (rr_last == CH_B) ? GNT_A : GNT_B;
    end else if (a_full) begin
      g = GNT_A;
    end else if (b_full) begin
      g = GNT_B;
    end
    return g;
  endfunction

endpackage

// File: rtl/sel_arb2_if.sv
// Producer-side valid/ready pairs and downstream select/data outputs of sel_arb2.
interface sel_arb2_if #(
    parameter int WIDTH = 1
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             selA;
    logic [WIDTH-1:0] QA;
    logic             selB;
    logic [WIDTH-1:0] QB;

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, selA, QA, selB, QB
    );

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, selA, QA, selB, QB
    );
endinterface

// File: rtl/sel_arb_slot.sv
// One-entry channel buffer; a drain and an accept on the same edge keep it full with the new word.
module sel_arb_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready = !full_q || drain;
    assign full     = full_q;
    assign data     = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/sel_arb2.sv
// Round-robin arbiter between two buffered channels driving mutually exclusive registered selects.
module sel_arb2
    import sel_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    sel_arb2_if.slave  bus
);
    logic             a_full, b_full;
    logic [WIDTH-1:0] a_buf, b_buf;
    logic             drain_a, drain_b;
    gnt_t             gnt;

    ch_t              rr_last_q, rr_last_d;
    logic             selA_q, selA_d;
    logic             selB_q, selB_d;
    logic [WIDTH-1:0] QA_q, QA_d;
    logic [WIDTH-1:0] QB_q, QB_d;

    sel_arb_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.a_valid),
        .in_data  (bus.a_data),
        .in_ready (bus.a_ready),
        .drain    (drain_a),
        .full     (a_full),
        .data     (a_buf)
    );

    sel_arb_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.b_valid),
        .in_data  (bus.b_data),
        .in_ready (bus.b_ready),
        .drain    (drain_b),
        .full     (b_full),
        .data     (b_buf)
    );

    assign gnt     = pick_grant(a_full, b_full, rr_last_q);
    assign drain_a = (gnt == GNT_A);
    assign drain_b = (gnt == GNT_B);

    always_comb begin
        rr_last_d = rr_last_q;
        selA_d    = 1'b0;
        selB_d    = 1'b0;
        QA_d      = QA_q;
        QB_d      = QB_q;
        case (gnt)
            GNT_A: begin
                selA_d    = 1'b1;
                QA_d      = a_buf;
                rr_last_d = CH_A;
            end
            GNT_B: begin
                selB_d    = 1'b1;
                QB_d      = b_buf;
                rr_last_d = CH_B;
            end
            default: ;
        endcase
    end

    // rr_last resets to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= CH_B;
            selA_q    <= 1'b0;
            selB_q    <= 1'b0;
            QA_q      <= '0;
            QB_q      <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            selA_q    <= selA_d;
            selB_q    <= selB_d;
            QA_q      <= QA_d;
            QB_q      <= QB_d;
        end
    end

    assign bus.selA = selA_q;
    assign bus.selB = selB_q;
    assign bus.QA   = QA_q;
    assign bus.QB   = QB_q;
endmodule

// File: tb/tb_sel_arb2.sv
// Self-checking bench for sel_arb2: directed vector table, corner sequences, random run with reference model.
module tb_sel_arb2;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sel_arb2_if #(.WIDTH(W)) bus ();
    sel_arb2 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream capture stage as the arbiter's consumer sees it.
    logic [W-1:0] dq = '0;
    always @(posedge clk) begin
        if (bus.selA) dq <= bus.QA;
        else if (bus.selB) dq <= bus.QB;
    end

    a_mutex: assert property (@(posedge clk) !(bus.selA && bus.selB))
        else begin fails++; $display("FAIL mutex_assert: selA=%0d selB=%0d", bus.selA, bus.selB); end
    a_capA: assert property (@(posedge clk) disable iff (rst) bus.selA |=> dq == $past(bus.QA))
        else begin fails++; $display("FAIL capA_assert: got %0d", dq); end
    a_capB: assert property (@(posedge clk) disable iff (rst) bus.selB |=> dq == $past(bus.QB))
        else begin fails++; $display("FAIL capB_assert: got %0d", dq); end

    // Reference model: per-channel pending words, last granted channel, registered outputs.
    logic [W-1:0] mq_a[$], mq_b[$];
    int           m_last;
    logic         m_selA, m_selB;
    logic [W-1:0] m_QA, m_QB;
    logic [W-1:0] sb_a[$], sb_b[$];

    function automatic void model_reset();
        mq_a.delete(); mq_b.delete(); sb_a.delete(); sb_b.delete();
        m_last = 1;
        m_selA = 1'b0; m_selB = 1'b0;
        m_QA = '0; m_QB = '0;
    endfunction

    task automatic cyc(input logic av, input logic [W-1:0] ad, input logic bv, input logic [W-1:0] bd,
                       output logic acc_a, output logic acc_b);
        int g;
        logic ra, rb;
        logic [W-1:0] w;
        bus.a_valid = av; bus.a_data = ad;
        bus.b_valid = bv; bus.b_data = bd;
        @(negedge clk);
        if (mq_a.size() == 0 && mq_b.size() == 0) g = 0;
        else if (mq_b.size() == 0) g = 1;
        else if (mq_a.size() == 0) g = 2;
        else g = (m_last == 1) ? 1 : 2;
        ra = (mq_a.size() == 0) || (g == 1);
        rb = (mq_b.size() == 0) || (g == 2);
        chk("a_ready", int'(bus.a_ready), int'(ra));
        chk("b_ready", int'(bus.b_ready), int'(rb));
        chk("selA", int'(bus.selA), int'(m_selA));
        chk("selB", int'(bus.selB), int'(m_selB));
        chk("QA", int'(bus.QA), int'(m_QA));
        chk("QB", int'(bus.QB), int'(m_QB));
        chk("mutex", int'(bus.selA && bus.selB), 0);
        if (bus.selA) begin
            tests++;
            if (sb_a.size() == 0) begin
                fails++; $display("FAIL sbA: selA with no outstanding word at %0t", $time);
            end else begin
                w = sb_a.pop_front();
                chk("sbA_order", int'(bus.QA), int'(w));
            end
        end
        if (bus.selB) begin
            tests++;
            if (sb_b.size() == 0) begin
                fails++; $display("FAIL sbB: selB with no outstanding word at %0t", $time);
            end else begin
                w = sb_b.pop_front();
                chk("sbB_order", int'(bus.QB), int'(w));
            end
        end
        acc_a = av && bus.a_ready;
        acc_b = bv && bus.b_ready;
        if (acc_a) sb_a.push_back(ad);
        if (acc_b) sb_b.push_back(bd);
        m_selA = (g == 1);
        m_selB = (g == 2);
        if (g == 1) begin m_QA = mq_a.pop_front(); m_last = 0; end
        if (g == 2) begin m_QB = mq_b.pop_front(); m_last = 1; end
        if (av && ra) mq_a.push_back(ad);
        if (bv && rb) mq_b.push_back(bd);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        bus.a_data = '0; bus.b_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic r, av; logic [W-1:0] ad; logic bv; logic [W-1:0] bd;
        logic ea, eb, esa; logic [W-1:0] eqa; logic esb; logic [W-1:0] eqb;
    } vec_t;
    vec_t tbl[12];

    initial begin
        logic xa, xb;
        int na, nb;
        // r  av ad   bv bd    a_rdy b_rdy selA QA   selB QB
        tbl[0]  = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0};

        // Reset, then ten idle cycles.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, '0, xa, xb);

        // Directed table: A-only stream, mid-table reset, then a first-edge tie.
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r;
            bus.a_valid = tbl[i].av; bus.a_data = tbl[i].ad;
            bus.b_valid = tbl[i].bv; bus.b_data = tbl[i].bd;
            @(negedge clk);
            chk($sformatf("tbl%0d_a_ready", i), int'(bus.a_ready), int'(tbl[i].ea));
            chk($sformatf("tbl%0d_b_ready", i), int'(bus.b_ready), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_selA", i), int'(bus.selA), int'(tbl[i].esa));
            chk($sformatf("tbl%0d_QA", i), int'(bus.QA), int'(tbl[i].eqa));
            chk($sformatf("tbl%0d_selB", i), int'(bus.selB), int'(tbl[i].esb));
            chk($sformatf("tbl%0d_QB", i), int'(bus.QB), int'(tbl[i].eqb));
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // Both channels saturated: words advance only when accepted.
        do_reset();
        na = 1; nb = 9;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, W'(na), 1'b1, W'(nb), xa, xb);
            if (xa) na++;
            if (xb) nb++;
        end
        chk("sat_acceptsA", na - 1, 6);
        chk("sat_acceptsB", nb - 9, 5);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, xa, xb);

        // Reset while both buffers are full and selB is high.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd3, 1'b1, 4'd5, xa, xb);
        @(negedge clk);
        chk("pre_rst_selB", int'(bus.selB), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_selA", int'(bus.selA), 0);
        chk("async_rst_selB", int'(bus.selB), 0);
        chk("async_rst_a_ready", int'(bus.a_ready), 1);
        chk("async_rst_b_ready", int'(bus.b_ready), 1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, xa, xb);
        cyc(1'b1, 4'd7, 1'b1, 4'd2, xa, xb);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, xa, xb);

        // Random traffic against the model and scoreboard.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0, W'($urandom), xa, xb);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, '0, xa, xb);
        chk("sbA_drained", sb_a.size(), 0);
        chk("sbB_drained", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
